fetch_ex_queue: RTL
===================

Name: fetch_ex_queue

Overview:
- Parametrised successor to the single-entry fetch→execute pipeline register: a DEPTH-entry in-order queue of fetch_ex_pipeline_reg_t entries between the fetch stage and the execute stage.
- Computes pc4 internally.
- Pre-decodes a control-flow flag per entry.
- Supports a single-cycle flush for branch mispredicts and traps.
- Decouples fetch from execute stalls without losing the token/prediction information carried today.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived; not overridden).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  reset, synchronous, active-low.
- enq_valid  input  1  fetch offers an entry.
- enq_ready  output  1  queue can accept an entry this cycle.
- enq_pc  input  WORD_SIZE  PC of the fetched instruction.
- enq_instr  input  WORD_SIZE  instruction word.
- enq_prediction  input  WORD_SIZE  predicted next PC.
- deq_valid  output  1  head entry is valid.
- deq_ready  input  1  execute consumes the head entry.
- deq_entry  output  $bits(fetch_ex_pipeline_reg_t)  head entry (token, pc, pc4, instr, prediction).
- deq_is_cf  output  1  head opcode is JAL, JALR or BRANCH.
- flush  input  1  discard all entries.
- count  output  CNT_W  current occupancy.

Behaviour:
- Reset, sampled on CLK when nRST=0:
  - Pointers and count go to 0.
  - All storage, including the cf flags, clears to 0.
  - Outputs: deq_valid=0, deq_entry=0, deq_is_cf=0, count=0, enq_ready=1 (once out of reset).
  - Reset dominates flush, enq and deq in the same cycle.
- Storage:
  - Circular array indexed by wr_ptr/rd_ptr (PTR_W bits).
  - Pointers wrap naturally from DEPTH-1 to 0.
  - count tracks occupancy and distinguishes full from empty.
- Enqueue: enq_fire = enq_valid & enq_ready & ~flush. On enq_fire, store:
  - token=1
  - pc=enq_pc
  - pc4=enq_pc+4 (WORD_SIZE modulo; 0xFFFFFFFC → 0x00000000)
  - instr=enq_instr
  - prediction=enq_prediction
  - cf flag = opcode field (instr[6:0]) ∈ {JAL, JALR, BRANCH}
  - Then wr_ptr advances.
- Dequeue: deq_fire = deq_valid & deq_ready & ~flush. On deq_fire, rd_ptr advances.
- deq_entry and deq_is_cf read combinationally from storage at rd_ptr. When empty they show the stale slot; consumers qualify them with deq_valid.
- enq_ready = (count != DEPTH) & ~flush. It does not depend on deq_ready, so there is no comb path deq→enq. A full queue does not accept an entry in a cycle in which it dequeues.
- deq_valid = (count != 0) & ~flush.
- count next value:
  - +1 on enq_fire only.
  - −1 on deq_fire only.
  - Unchanged when both fire or neither fires.
  - Latency enqueue→deq_valid is 1 cycle. Full throughput is 1 entry/cycle at steady state when not full.
- Flush, synchronous:
  - In the flush cycle, enq_ready and deq_valid are forced 0 and the offered enq/deq are dropped.
  - Next cycle: count=0, rd_ptr=wr_ptr=0, and deq_valid=0.
  - Storage contents are not cleared; token is irrelevant while invalid.
  - Enqueue is accepted again on the cycle after flush.
- Occupancy states, implied by count:
  - EMPTY (0): no dequeue possible.
  - PARTIAL: enq and deq both allowed.
  - FULL (DEPTH): no enqueue possible.
- Ordering: strict FIFO, no reordering, no bypass of an empty queue.

Decomposition:
- Add function is_control_flow(opcode_t) to rv32i_types_pkg.
- Reuse word_t, opcode_t and fetch_ex_pipeline_reg_t from that package; no new struct is required.
- No sub-module. Storage, pointers and control live in one module of about 150 lines.

Test Plan:
1. Reset:
   - Stimulus: hold nRST=0 for 2 cycles with enq_valid=1.
   - Required: count=0, deq_valid=0, deq_entry=0, enq_ready=1 after release.
2. Single pass:
   - Stimulus: enqueue pc=0x100, instr=0x0000006F (JAL), prediction=0x200.
   - Required, next cycle: deq_valid=1, pc4=0x104, token=1, deq_is_cf=1, count=1.
3. Fill and wrap (DEPTH=4):
   - Stimulus: enqueue pc 0x0,0x4,0x8,0xC with deq_ready=0.
   - Required: enq_ready=0 and count=4.
   - Stimulus: drain 2, then enqueue 0x10,0x14.
   - Required: dequeue order 0x8,0xC,0x10,0x14; no loss after the pointers wrap.
4. Simultaneous enq/deq at count=2:
   - Required: count stays 2 and order is preserved.
   - Stimulus: at count=4 with deq_ready=1 and enq_valid=1.
   - Required: only the dequeue occurs, count becomes 3.
5. Flush:
   - Stimulus: count=3, assert flush together with enq_valid and deq_ready.
   - Required: in that cycle deq_valid=0 and enq_ready=0; next cycle count=0; the following enqueue (pc=0x400) is the next entry dequeued.
6. pc4 wrap and cf decode:
   - Stimulus: enqueue pc=0xFFFFFFFC, instr=0x00000013 (ADDI).
   - Required: pc4=0x00000000, deq_is_cf=0.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// RV32I shared types: word, opcode encoding and the fetch->execute pipeline entry.
// Also holds the control-flow pre-decode helper used by the fetch queue.
package rv32i_types_pkg;

    localparam int WORD_SIZE = 32;

    typedef logic [WORD_SIZE-1:0] word_t;

    typedef enum logic [6:0] {
        OP_LUI     = 7'b0110111,
        OP_AUIPC   = 7'b0010111,
        OP_JAL     = 7'b1101111,
        OP_JALR    = 7'b1100111,
        OP_BRANCH  = 7'b1100011,
        OP_LOAD    = 7'b0000011,
        OP_STORE   = 7'b0100011,
        OP_ITYPE   = 7'b0010011,
        OP_RTYPE   = 7'b0110011,
        OP_MISCMEM = 7'b0001111,
        OP_SYSTEM  = 7'b1110011
    } opcode_t;

    typedef struct packed {
        logic  token;
        word_t pc;
        word_t pc4;
        word_t instr;
        word_t prediction;
    } fetch_ex_pipeline_reg_t;

    function automatic logic is_control_flow(input opcode_t op);
        return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/fetch_ex_queue.sv
// DEPTH-entry in-order queue between fetch and execute, with pc4 generation,
// control-flow pre-decode per entry and a single-cycle flush.
module fetch_ex_queue
    import rv32i_types_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  word_t                  enq_pc,
    input  word_t                  enq_instr,
    input  word_t                  enq_prediction,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output fetch_ex_pipeline_reg_t deq_entry,
    output logic                   deq_is_cf,
    input  logic                   flush,
    output logic [CNT_W-1:0]       count
);

    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg;

    fetch_ex_pipeline_reg_t slot_entry [DEPTH];
    logic [DEPTH-1:0]       slot_cf;
    logic [DEPTH-1:0]       slot_we;

    fetch_ex_pipeline_reg_t enq_entry;
    logic                   enq_is_cf;
    logic                   full;
    logic                   empty;
    logic                   enq_fire;
    logic                   deq_fire;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // Handshakes depend only on occupancy and flush, never on the other side's
    // ready, so a full queue cannot accept in the same cycle it drains.
    assign enq_ready = ~full & ~flush;
    assign deq_valid = ~empty & ~flush;
    assign enq_fire  = enq_valid & enq_ready;
    assign deq_fire  = deq_valid & deq_ready;

    always_comb begin
        enq_entry            = '0;
        enq_entry.token      = 1'b1;
        enq_entry.pc         = enq_pc;
        enq_entry.pc4        = enq_pc + word_t'(4);
        enq_entry.instr      = enq_instr;
        enq_entry.prediction = enq_prediction;
    end

    assign enq_is_cf = is_control_flow(opcode_t'(enq_instr[6:0]));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            fetch_ex_pipeline_reg_t entry_reg;
            logic                   cf_reg;

            assign slot_we[gi] = enq_fire & (wr_ptr_reg == PTR_W'(gi));

            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    entry_reg <= '0;
                    cf_reg    <= 1'b0;
                end else if (slot_we[gi]) begin
                    entry_reg <= enq_entry;
                    cf_reg    <= enq_is_cf;
                end
            end

            assign slot_entry[gi] = entry_reg;
            assign slot_cf[gi]    = cf_reg;
        end
    endgenerate

    // Flush rewinds both pointers; slot contents are left stale on purpose.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (deq_fire) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign deq_entry = slot_entry[rd_ptr_reg];
    assign deq_is_cf = slot_cf[rd_ptr_reg];
    assign count     = count_reg;

endmodule
